// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences the multicycle RISC-V datapath through IF/ID/EX/MEM/WB and counts retired instructions
module multicycle_controller #(
  parameter int STATE_W = 3,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  input  logic               is_halted,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               is_ecall,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    S_IF   = STATE_W'(0),
    S_ID   = STATE_W'(1),
    S_EX   = STATE_W'(2),
    S_MEM  = STATE_W'(3),
    S_WB   = STATE_W'(4),
    S_HALT = STATE_W'(5)
  } state_t;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_ecall, w_known;
  logic w_pc_write, w_pc_write_cond, w_pc_source, w_i_or_d, w_mem_read, w_mem_write;
  logic w_ir_write, w_reg_write, w_alu_src_a, w_is_ecall, w_halted;
  logic [1:0] w_mem_to_reg, w_alu_src_b, w_alu_op;
  assign w_r     = opcode == OP_R;
  assign w_i     = opcode == OP_I;
  assign w_ld    = opcode == OP_LD;
  assign w_st    = opcode == OP_ST;
  assign w_br    = opcode == OP_BR;
  assign w_jal   = opcode == OP_JAL;
  assign w_jalr  = opcode == OP_JALR;
  assign w_ecall = opcode == OP_ECALL;
  assign w_known = w_r | w_i | w_ld | w_st | w_br | w_jal | w_jalr;
  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 2'd0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'd0;
    w_alu_op        = 2'd0;
    w_is_ecall      = 1'b0;
    w_halted        = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_read = 1'b1;
        w_ir_write = mem_ready;
        w_next     = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        w_alu_src_b = 2'd2;
        w_is_ecall  = w_ecall;
        // ecall without halt and unknown opcodes both retire here as a NOP
        w_pc_write  = ~w_known & ~(w_ecall & is_halted);
        w_next      = (w_ecall & is_halted) ? S_HALT : w_known ? S_EX : S_IF;
      end
      S_EX: begin
        w_alu_src_a     = ~w_jal;
        w_alu_src_b     = (w_r | w_br) ? 2'd0 : 2'd2;
        w_alu_op        = (w_r | w_i) ? 2'd2 : w_br ? 2'd1 : 2'd0;
        w_pc_write_cond = w_br;
        w_pc_source     = w_br;
        w_next          = (w_ld | w_st) ? S_MEM : (w_known & ~w_br) ? S_WB : S_IF;
      end
      S_MEM: begin
        w_i_or_d    = 1'b1;
        w_mem_read  = w_ld;
        w_mem_write = w_st;
        w_pc_write  = w_st & mem_ready;
        w_next      = ~mem_ready ? S_MEM : w_ld ? S_WB : S_IF;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_mem_to_reg = w_ld ? 2'd1 : (w_jal | w_jalr) ? 2'd2 : 2'd0;
        w_pc_source  = w_jal | w_jalr;
        w_next       = S_IF;
      end
      S_HALT: w_halted = 1'b1;
      default: w_next = S_IF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IF;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_retired <= r_retired + CNT_W'(w_pc_write | w_pc_write_cond);
    end
  end
  // reset masks every output but state so an aborted instruction issues no writes
  assign pc_write      = w_pc_write & ~reset;
  assign pc_write_cond = w_pc_write_cond & ~reset;
  assign pc_source     = w_pc_source & ~reset;
  assign i_or_d        = w_i_or_d & ~reset;
  assign mem_read      = w_mem_read & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign ir_write      = w_ir_write & ~reset;
  assign mem_to_reg    = reset ? 2'd0 : w_mem_to_reg;
  assign reg_write     = w_reg_write & ~reset;
  assign alu_src_a     = w_alu_src_a & ~reset;
  assign alu_src_b     = reset ? 2'd0 : w_alu_src_b;
  assign alu_op        = reset ? 2'd0 : w_alu_op;
  assign is_ecall      = w_is_ecall & ~reset;
  assign halted        = w_halted & ~reset;
  assign retired       = reset ? '0 : r_retired;
  assign state         = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of state, control word and retired count
module tb_multicycle_controller;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic mem_ready = 1'b0;
  logic is_halted = 1'b0;
  logic pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic reg_write, alu_src_a, is_ecall, halted;
  logic [1:0] mem_to_reg, alu_src_b, alu_op;
  logic [31:0] retired;
  logic [2:0] state;
  logic [16:0] ctl;
  int n_checks = 0;
  int n_fail = 0;
  logic [16:0] c_if_rdy, c_if_wait, c_id, c_id_nop, c_id_ec, c_id_eh;
  logic [16:0] c_ex_r, c_ex_i, c_ex_ls, c_ex_br, c_ex_jal, c_ex_jalr;
  logic [16:0] c_mem_ld, c_mem_st_w, c_mem_st_r, c_wb_a, c_wb_ld, c_wb_j, c_halt;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .is_halted(is_halted),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_ecall(is_ecall), .halted(halted), .retired(retired), .state(state)
  );
  assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_ecall, halted};
  always #5 clk = ~clk;
  function automatic logic [16:0] mk(input int pw, pwc, ps, iod, mr, mw, irw, m2r, rw, asa, asb, aop, ec, h);
    return {1'(pw), 1'(pwc), 1'(ps), 1'(iod), 1'(mr), 1'(mw), 1'(irw), 2'(m2r), 1'(rw),
            1'(asa), 2'(asb), 2'(aop), 1'(ec), 1'(h)};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic hlt,
                     input logic rst, input logic [2:0] st, input logic [16:0] ctl_e, input int ret);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    is_halted = hlt;
    reset = rst;
    #1;
    check({tag, ".st"}, 32'(state), 32'(st));
    check({tag, ".ctl"}, 32'(ctl), 32'(ctl_e));
    check({tag, ".ret"}, retired, 32'(ret));
  endtask
  initial begin
    c_if_rdy   = mk(0,0,0,0,1,0,1,0,0,0,0,0,0,0);
    c_if_wait  = mk(0,0,0,0,1,0,0,0,0,0,0,0,0,0);
    c_id       = mk(0,0,0,0,0,0,0,0,0,0,2,0,0,0);
    c_id_nop   = mk(1,0,0,0,0,0,0,0,0,0,2,0,0,0);
    c_id_ec    = mk(1,0,0,0,0,0,0,0,0,0,2,0,1,0);
    c_id_eh    = mk(0,0,0,0,0,0,0,0,0,0,2,0,1,0);
    c_ex_r     = mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0);
    c_ex_i     = mk(0,0,0,0,0,0,0,0,0,1,2,2,0,0);
    c_ex_ls    = mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    c_ex_br    = mk(0,1,1,0,0,0,0,0,0,1,0,1,0,0);
    c_ex_jal   = mk(0,0,0,0,0,0,0,0,0,0,2,0,0,0);
    c_ex_jalr  = mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    c_mem_ld   = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0);
    c_mem_st_w = mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0);
    c_mem_st_r = mk(1,0,0,1,0,1,0,0,0,0,0,0,0,0);
    c_wb_a     = mk(1,0,0,0,0,0,0,0,1,0,0,0,0,0);
    c_wb_ld    = mk(1,0,0,0,0,0,0,1,1,0,0,0,0,0);
    c_wb_j     = mk(1,0,1,0,0,0,0,2,1,0,0,0,0,0);
    c_halt     = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    cyc("rst",  OP_R, 1, 0, 1, 0, 17'd0, 0);
    cyc("r_if", OP_R, 1, 0, 0, 0, c_if_rdy, 0);
    cyc("r_id", OP_R, 1, 0, 0, 1, c_id, 0);
    cyc("r_ex", OP_R, 1, 0, 0, 2, c_ex_r, 0);
    cyc("r_wb", OP_R, 1, 0, 0, 4, c_wb_a, 0);
    cyc("ld_if0", OP_LD, 0, 0, 0, 0, c_if_wait, 1);
    cyc("ld_if1", OP_LD, 0, 0, 0, 0, c_if_wait, 1);
    cyc("ld_if2", OP_LD, 1, 0, 0, 0, c_if_rdy, 1);
    cyc("ld_id",  OP_LD, 1, 0, 0, 1, c_id, 1);
    cyc("ld_ex",  OP_LD, 1, 0, 0, 2, c_ex_ls, 1);
    cyc("ld_m0",  OP_LD, 0, 0, 0, 3, c_mem_ld, 1);
    cyc("ld_m1",  OP_LD, 0, 0, 0, 3, c_mem_ld, 1);
    cyc("ld_m2",  OP_LD, 0, 0, 0, 3, c_mem_ld, 1);
    cyc("ld_m3",  OP_LD, 1, 0, 0, 3, c_mem_ld, 1);
    cyc("ld_wb",  OP_LD, 1, 0, 0, 4, c_wb_ld, 1);
    cyc("st_if",  OP_ST, 1, 0, 0, 0, c_if_rdy, 2);
    cyc("st_id",  OP_ST, 1, 0, 0, 1, c_id, 2);
    cyc("st_ex",  OP_ST, 1, 0, 0, 2, c_ex_ls, 2);
    cyc("st_m0",  OP_ST, 0, 0, 0, 3, c_mem_st_w, 2);
    cyc("st_m1",  OP_ST, 1, 0, 0, 3, c_mem_st_r, 2);
    cyc("br_if",  OP_BR, 1, 0, 0, 0, c_if_rdy, 3);
    cyc("br_id",  OP_BR, 1, 0, 0, 1, c_id, 3);
    cyc("br_ex",  OP_BR, 1, 0, 0, 2, c_ex_br, 3);
    cyc("jal_if", OP_JAL, 1, 0, 0, 0, c_if_rdy, 4);
    cyc("jal_id", OP_JAL, 1, 0, 0, 1, c_id, 4);
    cyc("jal_ex", OP_JAL, 1, 0, 0, 2, c_ex_jal, 4);
    cyc("jal_wb", OP_JAL, 1, 0, 0, 4, c_wb_j, 4);
    cyc("jr_if",  OP_JALR, 1, 0, 0, 0, c_if_rdy, 5);
    cyc("jr_id",  OP_JALR, 1, 0, 0, 1, c_id, 5);
    cyc("jr_ex",  OP_JALR, 1, 0, 0, 2, c_ex_jalr, 5);
    cyc("jr_wb",  OP_JALR, 1, 0, 0, 4, c_wb_j, 5);
    cyc("i_if",   OP_I, 1, 0, 0, 0, c_if_rdy, 6);
    cyc("i_id",   OP_I, 1, 0, 0, 1, c_id, 6);
    cyc("i_ex",   OP_I, 1, 0, 0, 2, c_ex_i, 6);
    cyc("i_wb",   OP_I, 1, 0, 0, 4, c_wb_a, 6);
    cyc("nop_if", OP_NOP, 1, 0, 0, 0, c_if_rdy, 7);
    cyc("nop_id", OP_NOP, 1, 0, 0, 1, c_id_nop, 7);
    cyc("ec_if",  OP_ECALL, 1, 1, 0, 0, c_if_rdy, 8);
    cyc("ec_id",  OP_ECALL, 1, 0, 0, 1, c_id_ec, 8);
    cyc("eh_if",  OP_ECALL, 1, 0, 0, 0, c_if_rdy, 9);
    cyc("eh_id",  OP_ECALL, 1, 1, 0, 1, c_id_eh, 9);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("halt%0d", i), (i % 2 == 0) ? OP_R : OP_ECALL, 1'(i % 3 != 0), 1'(i % 2), 0, 5, c_halt, 9);
    cyc("h_rst",  OP_R, 1, 1, 1, 5, 17'd0, 0);
    cyc("p_if",   OP_R, 1, 0, 0, 0, c_if_rdy, 0);
    cyc("p_id",   OP_R, 1, 0, 0, 1, c_id, 0);
    cyc("p_ex",   OP_R, 1, 0, 0, 2, c_ex_r, 0);
    cyc("p_wb",   OP_R, 1, 0, 0, 4, c_wb_a, 0);
    cyc("sa_if",  OP_ST, 1, 0, 0, 0, c_if_rdy, 1);
    cyc("sa_id",  OP_ST, 1, 0, 0, 1, c_id, 1);
    cyc("sa_ex",  OP_ST, 1, 0, 0, 2, c_ex_ls, 1);
    cyc("sa_rst", OP_ST, 1, 0, 1, 3, 17'd0, 0);
    cyc("sa_aft", OP_ST, 1, 0, 0, 0, c_if_rdy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
